// File: rtl/util_axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II encoder: 3-bit sync, 16 data bits MSB first, odd parity.
// First sync half-bit on diff one cycle after handshake; tready only in IDLE and the last parity cycle.
module util_axis_1553_encoder #(
    parameter int clock_speed = 100000000
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic [7:0]  s_axis_tuser,
    output logic        s_axis_tready,
    output logic [1:0]  diff
);

    localparam int HALF = clock_speed / 2000000;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] PARITY = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_idx;
    logic [15:0]   r_word;
    logic          r_cmd;
    logic          r_par;
    logic          r_ready;
    logic [1:0]    r_diff;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [5:0]    w_idx_nxt;
    logic [15:0]   w_word_nxt;
    logic          w_cmd_nxt;
    logic          w_par_nxt;
    logic          w_ready_nxt;
    logic [1:0]    w_diff_nxt;
    logic [4:0]    w_dsel;
    logic          w_lvl;
    logic          w_type_ok;
    logic          w_last;
    logic          w_start;
    logic          w_unused;

    assign w_unused  = &{1'b0, s_axis_tuser[7:3]};
    assign w_type_ok = (s_axis_tuser[2:0] == 3'b001) || (s_axis_tuser[2:0] == 3'b010);
    assign w_last    = (r_state == PARITY) && (r_idx == 6'd39) && (r_cnt == CNT_LAST);
    assign w_start   = s_axis_tvalid && r_ready && w_type_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;
        w_cmd_nxt   = r_cmd;
        w_par_nxt   = r_par;
        if (w_start) begin
            w_state_nxt = SYNC;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_word_nxt  = s_axis_tdata;
            w_cmd_nxt   = (s_axis_tuser[2:0] == 3'b001);
            w_par_nxt   = ~^s_axis_tdata;
        end else if ((r_state == IDLE) || w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
            // Half-bit index 0..5 is sync, 6..37 data, 38..39 parity.
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 6'd1;
            if (w_idx_nxt < 6'd6)
                w_state_nxt = SYNC;
            else if (w_idx_nxt < 6'd38)
                w_state_nxt = DATA;
            else
                w_state_nxt = PARITY;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // diff is encoded from the next-state values so it lands in the same register stage.
    always_comb begin
        w_dsel = w_idx_nxt[4:0] - 5'd6;
        w_lvl  = 1'b0;
        case (w_state_nxt)
            SYNC:    w_lvl = w_cmd_nxt ^ (w_idx_nxt >= 6'd3);
            DATA:    w_lvl = w_word_nxt[4'd15 - w_dsel[4:1]] ^ w_dsel[0];
            PARITY:  w_lvl = w_par_nxt ^ w_idx_nxt[0];
            default: w_lvl = 1'b0;
        endcase
        w_diff_nxt  = (w_state_nxt == IDLE) ? 2'b00 : {w_lvl, ~w_lvl};
        w_ready_nxt = (w_state_nxt == IDLE) ||
                      ((w_state_nxt == PARITY) && (w_idx_nxt == 6'd39) && (w_cnt_nxt == CNT_LAST));
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_cmd   <= 1'b0;
            r_par   <= 1'b0;
            r_ready <= 1'b0;
            r_diff  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_word  <= w_word_nxt;
            r_cmd   <= w_cmd_nxt;
            r_par   <= w_par_nxt;
            r_ready <= w_ready_nxt;
            r_diff  <= w_diff_nxt;
        end
    end

    assign s_axis_tready = r_ready;
    assign diff          = r_diff;

endmodule

// File: tb/tb_util_axis_1553_encoder.sv
// Directed and randomized bench for util_axis_1553_encoder at 100 MHz (50 cycles per half-bit).
module tb_util_axis_1553_encoder;

    localparam int HALF = 50;
    localparam int W    = 40 * HALF;

    logic        aclk = 1'b0;
    logic        arstn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tuser;
    logic        s_axis_tready;
    logic [1:0]  diff;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    bit   exp_lv [W];
    logic obs_lv [W];

    util_axis_1553_encoder #(.clock_speed(100000000)) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .diff          (diff)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of 40 half-bit line levels, each stretched to HALF cycles.
    task automatic build_expected(input logic [15:0] d, input logic [2:0] t);
        bit h[$];
        bit p;
        h = {};
        for (int k = 0; k < 3; k++) h.push_back(t == 3'b001);
        for (int k = 0; k < 3; k++) h.push_back(t != 3'b001);
        p = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            h.push_back(d[k]);
            h.push_back(!d[k]);
            p ^= d[k];
        end
        h.push_back(p);
        h.push_back(!p);
        for (int c = 0; c < W; c++) exp_lv[c] = h[c / HALF];
    endtask

    // Present a word at a negedge; returns at the negedge just after the handshake edge.
    task automatic send(input logic [15:0] d, input logic [7:0] u);
        check("tready_before_send", {31'd0, s_axis_tready}, 32'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        @(negedge aclk);
    endtask

    // Observe one full word; ends on the negedge of its last cycle.
    task automatic run_word(input logic [15:0] d, input logic [7:0] u, input bit nxt_vld,
                            input logic [15:0] nd, input logic [7:0] nu, input string tag);
        int nbad;
        int rbad;
        logic [15:0] dec;
        nbad = 0;
        rbad = 0;
        build_expected(d, u[2:0]);
        for (int c = 0; c < W; c++) begin
            if (c == 1) begin
                s_axis_tvalid = nxt_vld;
                s_axis_tdata  = nd;
                s_axis_tuser  = nu;
            end
            if (diff !== {exp_lv[c], ~exp_lv[c]}) nbad++;
            if (s_axis_tready !== (c == W - 1)) rbad++;
            obs_lv[c] = diff[1];
            if (c != W - 1) @(negedge aclk);
        end
        check({tag, "_wave_bad_cycles"}, nbad, 0);
        check({tag, "_tready_bad_cycles"}, rbad, 0);
        check({tag, "_dec_type"}, obs_lv[HALF / 2] ? 32'd1 : 32'd2, {29'd0, u[2:0]});
        for (int k = 0; k < 16; k++) dec[15 - k] = obs_lv[6 * HALF + 2 * k * HALF + HALF / 2];
        check({tag, "_dec_data"}, {16'd0, dec}, {16'd0, d});
        check({tag, "_dec_odd_parity"}, {31'd0, ^{dec, obs_lv[38 * HALF + HALF / 2]}}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_diff"}, {30'd0, diff}, 32'd0);
        check({tag, "_idle_tready"}, {31'd0, s_axis_tready}, 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  u;
        logic [15:0] nd;
        logic [7:0]  nu;
        bit          chain;
        int          bad;

        arstn         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0;
        s_axis_tuser  = 8'h0;

        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("reset_diff", {30'd0, diff}, 32'd0);
            check("reset_tready", {31'd0, s_axis_tready}, 32'd0);
        end
        arstn = 1'b1;
        @(negedge aclk);
        check_idle("after_reset");

        send(16'h0000, 8'h01);
        run_word(16'h0000, 8'h01, 1'b0, 16'hDEAD, 8'h02, "w0000");
        @(negedge aclk);
        check_idle("w0000");

        send(16'hA5A5, 8'h02);
        run_word(16'hA5A5, 8'h02, 1'b0, 16'h1111, 8'h01, "wA5A5");
        @(negedge aclk);
        check_idle("wA5A5");

        // Back-to-back: tvalid held, second word picked up in the last parity cycle.
        send(16'h0001, 8'h01);
        run_word(16'h0001, 8'h01, 1'b1, 16'hFFFF, 8'h02, "b2b_first");
        @(negedge aclk);
        run_word(16'hFFFF, 8'h02, 1'b0, 16'h0F0F, 8'h01, "b2b_second");
        @(negedge aclk);
        check_idle("b2b");

        // Invalid type is consumed and never transmitted.
        send(16'h5A5A, 8'h07);
        s_axis_tvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if (diff !== 2'b00 || s_axis_tready !== 1'b1) bad++;
            @(negedge aclk);
        end
        check("invalid_type_bad_cycles", bad, 0);

        d = 16'($urandom);
        u = {5'($urandom), ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b010};
        send(d, u);
        for (int i = 0; i < 6; i++) begin
            chain = (i < 5) && ($urandom_range(0, 1) != 0);
            nd = 16'($urandom);
            nu = {5'($urandom), ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b010};
            run_word(d, u, chain, nd, nu, "rand");
            @(negedge aclk);
            if (!chain) begin
                check_idle("rand");
                if (i < 5) send(nd, nu);
            end
            d = nd;
            u = nu;
        end

        // Invalid word offered in the final parity cycle ends the stream.
        send(16'hC3C3, 8'hF9);
        run_word(16'hC3C3, 8'hF9, 1'b1, 16'h7777, 8'h00, "b2b_invalid");
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check_idle("b2b_invalid");
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            if (diff !== 2'b00) bad++;
        end
        check("b2b_invalid_stays_idle", bad, 0);

        // Reset in the middle of a word.
        send(16'hBEEF, 8'h01);
        s_axis_tvalid = 1'b0;
        repeat (699) @(negedge aclk);
        check("midword_diff_active", {31'd0, diff != 2'b00}, 32'd1);
        arstn = 1'b0;
        @(negedge aclk);
        check("midword_reset_diff", {30'd0, diff}, 32'd0);
        check("midword_reset_tready", {31'd0, s_axis_tready}, 32'd0);
        repeat (3) @(negedge aclk);
        arstn = 1'b1;
        @(negedge aclk);
        check_idle("after_midword_reset");
        send(16'h1234, 8'h01);
        run_word(16'h1234, 8'h01, 1'b0, 16'h0000, 8'h00, "w1234");
        @(negedge aclk);
        check_idle("w1234");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/util_axis_1553_encoder.md
# util_axis_1553_encoder

AXI-Stream to MIL-STD-1553 Manchester II encoder. Accepts one 16-bit word per transfer with a sync-type tag, and serializes it as a 20-bit-time word: 3-bit sync, 16 data bits MSB first, odd parity. It drives the differential pair `diff` toward the transceiver and sits directly upstream of `util_axis_1553_decoder`, which consumes its output in loopback.

## Interface
- `clock_speed`, 100000000: aclk frequency in Hz; must be an integer multiple of 2000000.
- `aclk`  in  1  system clock; all logic is on the rising edge.
- `arstn`  in  1  synchronous, active-low reset.
- `s_axis_tdata`  in  16  word to transmit; bit 15 is sent first.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tuser`  in  8  word type: [2:0]=3'b001 command/status sync, 3'b010 data sync, any other value is an invalid word; [7:3] are ignored.
- `s_axis_tready`  out  1  encoder can accept a word this cycle.
- `diff`  out  2  Manchester output; diff[1] is the positive line and diff[0] its complement while transmitting; 2'b00 when idle.

## Operation
- Constants: HALF = clock_speed/2000000 cycles per half-bit; one bit time = 2*HALF; one word = 40*HALF cycles.
- FSM states: IDLE, SYNC, DATA, PARITY.
  - IDLE: diff=00; tready=1. On tvalid&tready with a valid type, latch tdata and type, compute parity = ~^tdata, go to SYNC. An invalid type is accepted and discarded: stay in IDLE, diff stays 00.
  - SYNC: 6 half-bits. Command/status: diff[1] high for 3*HALF then low for 3*HALF. Data: diff[1] low for 3*HALF then high for 3*HALF. diff[0] = ~diff[1] throughout.
  - DATA: 16 bits, tdata[15] down to tdata[0]. Bit 1: diff[1] high the first HALF, low the second HALF. Bit 0: the opposite.
  - PARITY: one bit with the same encoding as DATA. In the last cycle, if tvalid is high with a valid type, reload and go directly to SYNC (back-to-back, zero gap). Otherwise go to IDLE.
- Counters: a half-bit cycle counter (0..HALF-1) and a half-bit index (0..39). Both reset on every word start.
- s_axis_tready is high in IDLE and in the final cycle of PARITY, and low otherwise. An invalid word presented in that final cycle is consumed and the FSM goes to IDLE.
- tdata and tuser are sampled only on handshake. Changes on the inputs during transmission have no effect.

## Timing
- Reset values while arstn=0 at a rising edge: diff=2'b00, s_axis_tready=0, FSM=IDLE, counters=0, latched word=0.
- s_axis_tready rises at the first rising edge with arstn=1.
- Latency: handshake at edge N, and the first sync half-bit is on diff from edge N+1. A word occupies exactly 40*HALF cycles.
- Back-to-back: the first sync cycle of word k+1 immediately follows the last parity cycle of word k, with no 00 cycle in between.
- Reset mid-word: at the first edge with arstn=0, diff=00 and tready=0. The partial word is lost. After release, the next word starts cleanly from SYNC.
- diff is registered and glitch-free. diff never equals 2'b11.

## Test plan
(clock_speed=100 MHz, HALF=50)
- Reset: hold arstn=0 for 10 cycles -> diff=00 and tready=0 throughout; tready=1 one edge after release.
- tdata=16'h0000, tuser=3'b001 -> diff[1] high for 150 cycles, low for 150, then 16 times (low 50, high 50), then parity 1 (high 50, low 50); diff=00 after 2000 cycles; decoder loopback returns 16'h0000 with command type.
- tdata=16'hA5A5, tuser=3'b010 -> diff[1] low 150 then high 150; bits decode as A5A5; parity 1 (8 ones); decoder reports data type.
- Two words 16'h0001 then 16'hFFFF with tvalid held -> tready pulses for one cycle at cycle 1999; exactly 4000 contiguous non-00 cycles; parity bits 0 then 1.
- tuser=3'b111 with tvalid=1 for 1 cycle -> accepted (tready=1); diff stays 00 for 3000 cycles.
- Reset asserted at cycle 700 of a word -> diff=00 at the next edge; after release, a new word 16'h1234 is encoded in full and decodes correctly.
